// File: rtl/instr_fetch_unit.sv
// Program counter and instruction fetch stage: fetches one word per step over a req/ack
// port, exposes it to the decoder for one EXEC cycle, then applies pc_sel to advance.
module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              RCNT_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        pc_sel,
    input  logic [XLEN-1:0]   alu_result,
    input  logic              program_done,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [6:0]        opcode,
    output logic [9:0]        functs,
    output logic              instr_valid,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   pc_plus4,
    output logic              halted,
    output logic              misalign,
    output logic [RCNT_W-1:0] retired
);

    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

    state_t          state;
    logic [XLEN-1:0] target;

    function automatic logic [XLEN-1:0] jimm_sext(input logic [31:0] w);
        logic signed [20:0] imm;
        imm = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        return {{(XLEN-21){imm[20]}}, imm};
    endfunction

    assign imem_addr = pc;
    assign pc_plus4  = pc + XLEN'(4);
    assign opcode    = instr[6:0];
    assign functs    = {instr[31:25], instr[14:12]};

    always_comb begin
        target = pc_plus4;
        case (pc_sel)
            2'b00:   target = pc_plus4;
            2'b01:   target = alu_result;
            2'b10:   target = pc + jimm_sext(instr);
            default: target = {alu_result[XLEN-1:1], 1'b0};
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr       <= 32'h0000_0013;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            misalign    <= 1'b0;
            retired     <= '0;
        end else begin
            case (state)
                FETCH: begin
                    // First FETCH cycle after reset only raises the request, so a stale ack is dropped.
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        instr       <= imem_rdata;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    instr_valid <= 1'b0;
                    if (program_done) begin
                        halted  <= 1'b1;
                        retired <= retired + RCNT_W'(1);
                        state   <= HALT;
                    end else if (target[1:0] != 2'b00) begin
                        misalign <= 1'b1;
                        halted   <= 1'b1;
                        state    <= HALT;
                    end else begin
                        pc       <= target;
                        retired  <= retired + RCNT_W'(1);
                        imem_req <= 1'b1;
                        state    <= FETCH;
                    end
                end
                HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    halted <= 1'b1;
                    state  <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: the driver queues each fetched word with its pc,
// and a monitor checks the decoder-facing outputs whenever instr_valid is presented.
module tb_instr_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  pc_sel;
    logic [31:0] alu_result;
    logic        program_done;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [9:0]  functs;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;
    logic        misalign;
    logic [31:0] retired;

    instr_fetch_unit dut (
        .clock       (clock),
        .reset       (reset),
        .pc_sel      (pc_sel),
        .alu_result  (alu_result),
        .program_done(program_done),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .functs      (functs),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .halted      (halted),
        .misalign    (misalign),
        .retired     (retired)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] cur_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && instr_valid) begin
            exp_t e;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: instr_valid at pc %h, expected none", pc);
            end else begin
                e = sb.pop_front();
                chk("sb_pc", pc, e.pc);
                chk("sb_instr", instr, e.word);
                chk("sb_opcode", 32'(opcode), 32'(e.word[6:0]));
                chk("sb_functs", 32'(functs), 32'({e.word[31:25], e.word[14:12]}));
                chk("sb_pc_plus4", pc_plus4, e.pc + 32'd4);
            end
        end
    end

    // Entered at a negedge with imem_req expected high at cur_pc.
    task automatic do_instr(input logic [31:0] word, input int waits, input logic [1:0] sel,
                            input logic [31:0] alu, input logic done,
                            input logic [31:0] next_pc, input logic exp_halt);
        imem_ack = 1'b0;
        repeat (waits) begin
            @(negedge clock);
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_addr", imem_addr, cur_pc);
            chk("wait_valid", 32'(instr_valid), 32'd0);
        end
        imem_ack     = 1'b1;
        imem_rdata   = word;
        pc_sel       = sel;
        alu_result   = alu;
        program_done = done;
        sb.push_back('{pc: cur_pc, word: word});
        @(negedge clock);
        chk("exec_valid", 32'(instr_valid), 32'd1);
        chk("exec_req", 32'(imem_req), 32'd0);
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        imem_ack     = 1'b0;
        program_done = 1'b0;
        chk("post_instr", instr, word);
        chk("post_valid", 32'(instr_valid), 32'd0);
        if (exp_halt) begin
            chk("halt_flag", 32'(halted), 32'd1);
            chk("halt_req", 32'(imem_req), 32'd0);
            chk("halt_pc", pc, cur_pc);
        end else begin
            chk("next_req", 32'(imem_req), 32'd1);
            chk("next_addr", imem_addr, next_pc);
            chk("next_halted", 32'(halted), 32'd0);
            cur_pc = next_pc;
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_instr"}, instr, 32'h0000_0013);
        chk({tag, "_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
        chk({tag, "_misalign"}, 32'(misalign), 32'd0);
        chk({tag, "_retired"}, retired, 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("refetch_req", 32'(imem_req), 32'd1);
        chk("refetch_addr", imem_addr, 32'h0);
        chk("refetch_valid", 32'(instr_valid), 32'd0);
        chk("refetch_instr", instr, 32'h0000_0013);
        cur_pc = 32'h0;
    endtask

    initial begin
        reset        = 1'b1;
        imem_ack     = 1'b0;
        imem_rdata   = 32'h0;
        pc_sel       = 2'b00;
        alu_result   = 32'h0;
        program_done = 1'b0;
        cur_pc       = 32'h0;
        repeat (2) @(negedge clock);
        chk_reset_state("rst0");
        release_reset();

        // Straight-line ADDIs at the minimum two-cycle rate
        do_instr(32'h0010_0093, 0, 2'b00, 32'h0, 1'b0, 32'h4, 1'b0);
        do_instr(32'h0020_0113, 0, 2'b00, 32'h0, 1'b0, 32'h8, 1'b0);
        do_instr(32'h0030_0193, 0, 2'b00, 32'h0, 1'b0, 32'hC, 1'b0);
        chk("retired_3", retired, 32'd3);

        // Ack held off for five FETCH cycles
        do_instr(32'h0000_0013, 5, 2'b00, 32'h0, 1'b0, 32'h10, 1'b0);
        // Branch to 0x40, JAL +0x100, JALR clears bit 0 of its target
        do_instr(32'h0000_0063, 0, 2'b01, 32'h40, 1'b0, 32'h40, 1'b0);
        do_instr(32'h1000_006F, 0, 2'b10, 32'h0, 1'b0, 32'h140, 1'b0);
        do_instr(32'h0000_8067, 0, 2'b11, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFC, 1'b0);
        // pc wraps through zero, then JAL -4 wraps back
        do_instr(32'h0000_0013, 0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0);
        do_instr(32'hFFDF_F06F, 0, 2'b10, 32'h0, 1'b0, 32'hFFFF_FFFC, 1'b0);
        chk("retired_9", retired, 32'd9);

        // JALR to 0x202 is misaligned: sticky flag, pc frozen, no retire
        do_instr(32'h0000_8067, 0, 2'b11, 32'h0000_0203, 1'b0, 32'h0, 1'b1);
        chk("misalign_set", 32'(misalign), 32'd1);
        chk("misalign_retired", retired, 32'd9);
        imem_ack = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("halt_hold_req", 32'(imem_req), 32'd0);
            chk("halt_hold_pc", pc, 32'hFFFF_FFFC);
        end
        imem_ack = 1'b0;

        // Async reset out of HALT
        #2 reset = 1'b1;
        #1 chk_reset_state("rst1");
        release_reset();

        // Branch to 0x80, then program_done halts and still retires
        do_instr(32'h0000_0063, 0, 2'b01, 32'h80, 1'b0, 32'h80, 1'b0);
        do_instr(32'h0000_0013, 0, 2'b00, 32'h0, 1'b1, 32'h0, 1'b1);
        chk("done_retired", retired, 32'd2);
        chk("done_misalign", 32'(misalign), 32'd0);
        repeat (3) begin
            @(negedge clock);
            chk("done_hold_req", 32'(imem_req), 32'd0);
            chk("done_hold_halted", 32'(halted), 32'd1);
            chk("done_hold_pc", pc, 32'h80);
        end

        #2 reset = 1'b1;
        #1 chk_reset_state("rst2");
        release_reset();
        do_instr(32'h0010_0093, 0, 2'b00, 32'h0, 1'b0, 32'h4, 1'b0);
        // Reset lands mid-fetch with an ack pending that must be ignored afterwards
        imem_ack = 1'b0;
        repeat (2) begin
            @(negedge clock);
            chk("mid_wait_addr", imem_addr, 32'h4);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h0BAD_0BAD;
        #2 reset = 1'b1;
        #1 chk_reset_state("rst3");
        release_reset();
        do_instr(32'h0020_0113, 0, 2'b00, 32'h0, 1'b0, 32'h4, 1'b0);
        chk("final_retired", retired, 32'd1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
